// File: rtl/input_debouncer.sv
// Synchronizes and debounces one asynchronous input, presenting a clean level
// plus single-cycle rise/fall pulses to the capture registers downstream.
module input_debouncer #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   CNT_WIDTH       = 16,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din_async,
   input  logic en,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   // Handshake-free block: din_async is sampled every edge; en is a plain
   // synchronous qualifier sampled on the same edge as the synchronized input.

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DB_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic                   dout_q;
   logic                   dout_d;
   logic                   rise_q;
   logic                   rise_d;
   logic                   fall_q;
   logic                   fall_d;

   // Synchronizer shift chain; runs independently of en.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din_async};
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         dout_q  <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // cnt counts the edges at which the candidate value has disagreed with dout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         ST_STABLE: begin
            if (en && (s != dout_q)) begin
               state_d = ST_COUNT;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_COUNT: begin
            if (!en || (s == dout_q)) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LIMIT) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
               dout_d  = s;
               rise_d  = s;
               fall_d  = ~s;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;
   assign busy = (state_q == ST_COUNT);

   a_pulse_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(rise_q && fall_q));

   a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
      cnt_q <= DB_LIMIT);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a run-length model checked every cycle,
// plus literal expectations at the edges where the level must change.
module tb_input_debouncer;

   localparam int   SYNC = 2;
   localparam int   DB   = 8;
   localparam logic RL   = 1'b0;
   // The first disagreeing edge opens the window; DB further edges confirm it.
   localparam int   NEED = DB + 1;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic din_async = 1'b1;
   logic en        = 1'b1;
   logic dout, rise, fall, busy;

   int checks    = 0;
   int errors    = 0;
   bit cmp_on    = 1'b0;
   int rise_seen = 0;
   int fall_seen = 0;
   int r0;
   int f0;

   always #5 clk = ~clk;

   input_debouncer #(
      .SYNC_STAGES    (SYNC),
      .CNT_WIDTH      (16),
      .DEBOUNCE_CYCLES(DB),
      .RESET_LEVEL    (RL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din_async(din_async),
      .en       (en),
      .dout     (dout),
      .rise     (rise),
      .fall     (fall),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: input delayed SYNC edges, then a count of consecutive qualifying edges.
   logic m_pipe [SYNC];
   logic m_dout, m_rise, m_fall, m_s;
   int   m_run;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC; i++) m_pipe[i] = RL;
         m_dout = RL;
         m_rise = 1'b0;
         m_fall = 1'b0;
         m_run  = 0;
      end else begin
         m_s    = m_pipe[SYNC-1];
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (en && (m_s != m_dout)) m_run = m_run + 1;
         else                       m_run = 0;
         if (m_run == NEED) begin
            m_dout = m_s;
            m_rise = m_s;
            m_fall = ~m_s;
            m_run  = 0;
         end
         for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = din_async;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_dout", dout, m_dout);
         chk("model_rise", rise, m_rise);
         chk("model_fall", fall, m_fall);
         chk("model_busy", busy, (m_run != 0));
         if (rise) rise_seen++;
         if (fall) fall_seen++;
      end
   end

   initial begin
      // 1: reset holds everything low even with din high; release and rise at edge 10.
      rst = 1'b1; din_async = 1'b1; en = 1'b1;
      #1;
      chk("t1_rst_dout", dout, 1'b0);
      chk("t1_rst_busy", busy, 1'b0);
      tick(3);
      chk("t1_rst_dout2", dout, 1'b0);
      chk("t1_rst_rise", rise, 1'b0);
      chk("t1_rst_fall", fall, 1'b0);
      chk("t1_rst_busy2", busy, 1'b0);
      cmp_on = 1'b1;
      rst = 1'b0;
      tick(10);
      chk("t1_dout_e9", dout, 1'b0);
      tick(1);
      chk("t1_dout_e10", dout, 1'b1);
      chk("t1_rise_e10", rise, 1'b1);
      tick(1);
      chk("t1_rise_e11", rise, 1'b0);
      chk("t1_dout_e11", dout, 1'b1);

      // 4: stable high, step low -> one fall at edge 10, no rise.
      r0 = rise_seen;
      din_async = 1'b0;
      tick(10);
      chk("t4_dout_e9", dout, 1'b1);
      chk("t4_fall_e9", fall, 1'b0);
      tick(1);
      chk("t4_fall_e10", fall, 1'b1);
      chk("t4_dout_e10", dout, 1'b0);
      chk("t4_rise_e10", rise, 1'b0);
      tick(1);
      chk("t4_fall_e11", fall, 1'b0);
      chk("t4_no_rise", rise_seen - r0, 0);

      // 3: seven-cycle glitch -> busy high edges 2..8, no output change.
      r0 = rise_seen; f0 = fall_seen;
      din_async = 1'b1;
      tick(2);
      chk("t3_busy_e1", busy, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         tick(1);
         chk("t3_busy_hi", busy, 1'b1);
         if (k == 6) din_async = 1'b0;
      end
      tick(1);
      chk("t3_busy_e9", busy, 1'b0);
      tick(4);
      chk("t3_dout", dout, 1'b0);
      chk("t3_no_pulse", (rise_seen - r0) + (fall_seen - f0), 0);

      // 2: toggle every 3 cycles for 30 cycles, then hold high.
      r0 = rise_seen;
      for (int seg = 0; seg < 10; seg++) begin
         din_async = (seg % 2 == 0);
         for (int j = 0; j < 3; j++) begin
            tick(1);
            chk("t2_bounce_dout", dout, 1'b0);
         end
      end
      din_async = 1'b1;
      tick(10);
      chk("t2_dout_e9", dout, 1'b0);
      tick(1);
      chk("t2_rise_e10", rise, 1'b1);
      chk("t2_dout_e10", dout, 1'b1);
      tick(2);
      chk("t2_one_rise", rise_seen - r0, 1);

      din_async = 1'b0;
      tick(14);
      chk("t2_back_low", dout, 1'b0);

      // 5: reset while counting (cnt = 5 after edge 6), then restart from zero.
      din_async = 1'b1;
      tick(7);
      chk("t5_busy_pre", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("t5_busy_async", busy, 1'b0);
      chk("t5_dout_async", dout, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(10);
      chk("t5_dout_e9", dout, 1'b0);
      tick(1);
      chk("t5_rise_e10", rise, 1'b1);
      chk("t5_dout_e10", dout, 1'b1);

      din_async = 1'b0;
      tick(14);
      chk("t5_back_low", dout, 1'b0);

      // 6: en low freezes dout; enabling starts the count, rise 8 edges later.
      r0 = rise_seen;
      en = 1'b0;
      din_async = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("t6_frozen_dout", dout, 1'b0);
         chk("t6_frozen_busy", busy, 1'b0);
      end
      en = 1'b1;
      tick(1);
      chk("t6_busy_e0", busy, 1'b1);
      tick(7);
      chk("t6_dout_e7", dout, 1'b0);
      tick(1);
      chk("t6_rise_e8", rise, 1'b1);
      chk("t6_dout_e8", dout, 1'b1);
      tick(2);
      chk("t6_one_rise", rise_seen - r0, 1);

      cmp_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
